// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_if
//  Description : Execute-stage <-> divider controller signal bundle.
//                master = execute stage / hazard side, slave = divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_ctrl_if;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [31:0] lo;
  logic [31:0] hi;

  modport master (output start, sign, a, b, flush,
                  input  stall, valid, lo, hi);

  modport slave  (input  start, sign, a, b, flush,
                  output stall, valid, lo, hi);
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Iterative restoring divider for DIV/DIVU. Works on operand
//                magnitudes, one quotient bit per cycle, then applies the
//                MIPS sign rules. Stalls the pipeline while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module div_ctrl #(
  parameter int ITER = 32
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  div_ctrl_if.slave   bus
);

  localparam int                CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       rem_q,   rem_d;    // partial remainder (always < divisor)
  logic [31:0]       quo_q,   quo_d;    // dividend shifting out / quotient in
  logic [31:0]       dvs_q,   dvs_d;    // divisor magnitude
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              sgn_q,   sgn_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic [31:0]       lo_q,    lo_d;
  logic [31:0]       hi_q,    hi_d;

  logic              accept;
  logic [31:0]       a_mag, b_mag;
  logic [32:0]       rem_sh;
  logic [32:0]       diff;
  logic              ge;
  logic [31:0]       rem_step, quo_step;
  logic [31:0]       quo_fix,  rem_fix;

  // Request acceptance, operand magnitudes and one restoring step
  always_comb begin
    accept = (state_q == IDLE) && bus.start && !bus.flush;
    a_mag  = (bus.sign && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    b_mag  = (bus.sign && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    // 33-bit shifted remainder; since rem < divisor the difference cannot
    // exceed 32 bits when non-negative, so bit 32 of diff is the borrow.
    rem_sh   = {rem_q, quo_q[31]};
    diff     = rem_sh - {1'b0, dvs_q};
    ge       = !diff[32];
    rem_step = ge ? diff[31:0] : rem_sh[31:0];
    quo_step = {quo_q[30:0], ge};
    quo_fix  = (sgn_q && (a_neg_q ^ b_neg_q)) ? (32'd0 - quo_step) : quo_step;
    rem_fix  = (sgn_q && a_neg_q) ? (32'd0 - rem_step) : rem_step;
  end

  // Next-state and datapath updates; flush overrides everything
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sgn_d   = bus.sign;
          a_neg_d = bus.a[31];
          b_neg_d = bus.b[31];
          rem_d   = 32'd0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = '0;
          if (bus.b == 32'd0) begin
            // Divide-by-zero result is defined on raw operands, no fix-up
            state_d = DONE;
            lo_d    = 32'hFFFF_FFFF;
            hi_d    = bus.a;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          lo_d    = quo_fix;
          hi_d    = rem_fix;
        end
      end
      DONE:    state_d = IDLE;   // start still high here is the same instruction
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
    end
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Combinational stall so the requesting instruction is held on arrival
  always_comb begin
    bus.stall = resetn && (accept || (state_q == BUSY));
    bus.valid = (state_q == DONE);
    bus.lo    = lo_q;
    bus.hi    = hi_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl. Expected results are
//                queued when a divide is launched and compared on valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl #(.ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  int          n_cmp      = 0;
  int          n_err      = 0;
  int          stall_run  = 0;
  int          last_len   = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_lo    = 32'd0;
  logic [31:0] last_hi    = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard compare on valid, stall run-length tracking
  always @(negedge clk) begin
    #2;
    if (!resetn) begin
      stall_run  = 0;
      prev_valid = 1'b0;
    end else begin
      if (bus.valid === 1'b1) begin
        check_eq("valid_single", {31'b0, prev_valid}, 32'd0);
        check_eq("valid_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("lo", bus.lo, mon_e.lo);
          check_eq("hi", bus.hi, mon_e.hi);
        end
      end
      if (bus.stall === 1'b1) begin
        stall_run++;
      end else if (stall_run != 0) begin
        last_len  = stall_run;
        stall_run = 0;
      end
      prev_valid = (bus.valid === 1'b1);
    end
  end

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Launch one divide, hold start through DONE; optionally keep start into
  // the following IDLE cycle, which must launch a second identical divide.
  task automatic do_div(input bit sg, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input int elen, input bit hold);
    bit seen;
    exp_q.push_back({elo, ehi});
    @(negedge clk);
    bus.sign  = sg;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    wait_valid(seen);
    check_eq("done_seen", {31'b0, seen}, 32'd1);
    check_eq("stall_len", 32'(last_len), 32'(elen));
    last_lo = elo;
    last_hi = ehi;
    @(negedge clk);
    if (hold) begin
      exp_q.push_back({elo, ehi});
      #3;
      check_eq("rearm_stall", {31'b0, bus.stall}, 32'd1);
      wait_valid(seen);
      check_eq("rearm_done_seen", {31'b0, seen}, 32'd1);
      check_eq("rearm_stall_len", 32'(last_len), 32'(elen));
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start = 1'b1;   // stall must stay low during reset regardless
    bus.sign  = 1'b0;
    bus.a     = 32'd5;
    bus.b     = 32'd1;
    bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    check_eq("rst_stall", {31'b0, bus.stall}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.valid}, 32'd0);
    check_eq("rst_lo", bus.lo, 32'd0);
    check_eq("rst_hi", bus.hi, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    resetn    = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    do_div(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 1'b0);
    do_div(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 1'b0);
    do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 1'b0);
    do_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33, 1'b0);
    do_div(1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1,  1'b0);
    do_div(1'b1, 32'h8000_0005,  32'd0,          32'hFFFF_FFFF,  32'h8000_0005,  1,  1'b0);

    // Random unsigned and signed cases against the language's own arithmetic
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      do_div(1'b0, ra, rb, ra / rb, ra % rb, 33, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i == 1) rb = 32'(-($urandom_range(1, 50)));
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      do_div(1'b1, ra, rb, 32'($signed(ra) / $signed(rb)), 32'($signed(ra) % $signed(rb)), 33, 1'b0);
    end

    // Start held through DONE into IDLE: exactly one valid, then relaunch
    do_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 1'b1);

    // Flush in the 10th BUSY cycle
    @(negedge clk);
    bus.sign  = 1'b0;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    #3;
    check_eq("flush_stall", {31'b0, bus.stall}, 32'd0);
    check_eq("flush_valid", {31'b0, bus.valid}, 32'd0);
    check_eq("flush_lo", bus.lo, last_lo);
    check_eq("flush_hi", bus.hi, last_hi);
    repeat (40) @(negedge clk);

    // Flush together with start in IDLE: nothing accepted
    bus.a     = 32'd77;
    bus.b     = 32'd5;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #3;
    check_eq("flush_start_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #3;
    check_eq("flush_start_idle", {31'b0, bus.stall}, 32'd0);
    repeat (40) @(negedge clk);
    #3;
    check_eq("flush_start_lo", bus.lo, last_lo);
    check_eq("flush_start_hi", bus.hi, last_hi);

    // Reset mid-BUSY
    @(negedge clk);
    bus.a     = 32'd500;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    repeat (6) @(negedge clk);
    resetn    = 1'b0;
    bus.start = 1'b0;
    #3;
    check_eq("midrst_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    #3;
    check_eq("midrst_lo", bus.lo, 32'd0);
    check_eq("midrst_hi", bus.hi, 32'd0);
    check_eq("midrst_valid", {31'b0, bus.valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery after reset
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
